// File: rtl/vga_menu_overlay_engine.sv
// vga_menu_overlay_engine: pipelined menu-screen pixel processor.
// Tracks raster X/Y, addresses the logo ROM, overlays border and selection box.
//
// Ports:
//   iVGA_CLK, iRST_n : pixel clock, synchronous active-low reset
//   frame_start      : pulse, next pix_valid is pixel (0,0); latches menu_sel
//   pix_valid        : one active pixel this cycle, raster order
//   menu_sel         : requested selection, clamped to NUM_OPTS-1
//   blink_en         : 1 = selection box blinks, 0 = steady
//   indexIn/colorIn  : ROM index and palette colour, one cycle after addrToRead
//   addrToRead       : ROM word address (logo pixel or blank word)
//   indexOut/colorOut/out_valid : final pixel, three cycles after acceptance
//   cur_sel          : selection currently drawn
module vga_menu_overlay_engine #(
    parameter int SEL_W      = 3,
    parameter int NUM_OPTS   = 5,
    parameter int ROWS       = 3,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int GRID_X0    = 130,
    parameter int GRID_Y0    = 224,
    parameter int COL_PITCH  = 227,
    parameter int ROW_PITCH  = 58,
    parameter int BOX_W      = 153,
    parameter int BOX_H      = 31,
    parameter int BOX_T      = 3,
    parameter int LOGO_BASE  = 25940,
    parameter int LOGO_X     = 204,
    parameter int LOGO_Y     = 40,
    parameter int LOGO_W     = 231,
    parameter int LOGO_H     = 156,
    parameter int BLANK_ADDR = 1923,
    parameter int BLINK_FR   = 16
) (
    input  logic             iVGA_CLK,
    input  logic             iRST_n,
    input  logic             frame_start,
    input  logic             pix_valid,
    input  logic [SEL_W-1:0] menu_sel,
    input  logic             blink_en,
    input  logic [7:0]       indexIn,
    input  logic [23:0]      colorIn,
    output logic [18:0]      addrToRead,
    output logic [7:0]       indexOut,
    output logic [23:0]      colorOut,
    output logic             out_valid,
    output logic [SEL_W-1:0] cur_sel
);

    localparam int X_W   = $clog2(H_RES);
    localparam int Y_W   = $clog2(V_RES);
    localparam int CNT_W = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;

    localparam logic [X_W-1:0]   X_LAST   = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_RES - 1);
    localparam logic [X_W-1:0]   X_ONE    = X_W'(1);
    localparam logic [Y_W-1:0]   Y_ONE    = Y_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FR - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [SEL_W-1:0] MAX_SEL  = SEL_W'(NUM_OPTS - 1);
    localparam logic [23:0]      WHITE    = 24'hFFFFFF;

    typedef enum logic {
        PH_VISIBLE = 1'b0,
        PH_HIDDEN  = 1'b1
    } phase_t;

    logic [X_W-1:0]   xCnt, xNext;
    logic [Y_W-1:0]   yCnt, yNext;
    logic [CNT_W-1:0] blinkCnt, blinkCntNext;
    phase_t           phase, phaseNext;
    logic [SEL_W-1:0] selClamp, selNext;

    int          px, py, bx, by;
    logic        onBorder, inBox, nearEdge, boxShown, inLogo;
    logic        white0;
    logic [18:0] addr0;

    logic v1, v2, w1, w2;

    // Raster position of the next accepted pixel
    always_comb begin
        xNext = xCnt + X_ONE;
        yNext = yCnt;
        if (xCnt == X_LAST) begin
            xNext = '0;
            yNext = (yCnt == Y_LAST) ? '0 : yCnt + Y_ONE;
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (frame_start) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (pix_valid) begin
            xCnt <= xNext;
            yCnt <= yNext;
        end
    end

    // Selection latch and blink phase, both only move on frame_start
    // so a frame is always drawn with one consistent box.
    always_comb begin
        selClamp     = (menu_sel > MAX_SEL) ? MAX_SEL : menu_sel;
        selNext      = cur_sel;
        blinkCntNext = blinkCnt;
        phaseNext    = phase;
        if (frame_start) begin
            selNext = selClamp;
            if (selClamp != cur_sel) begin
                // A new selection restarts the blink so it shows at once
                blinkCntNext = '0;
                phaseNext    = PH_VISIBLE;
            end else if (blinkCnt == CNT_LAST) begin
                blinkCntNext = '0;
                phaseNext    = (phase == PH_VISIBLE) ? PH_HIDDEN
                                                     : PH_VISIBLE;
            end else begin
                blinkCntNext = blinkCnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            cur_sel  <= '0;
            blinkCnt <= '0;
            phase    <= PH_VISIBLE;
        end else begin
            cur_sel  <= selNext;
            blinkCnt <= blinkCntNext;
            phase    <= phaseNext;
        end
    end

    // Overlay decision and ROM address for the pixel at (xCnt, yCnt)
    always_comb begin
        px = int'(xCnt);
        py = int'(yCnt);
        bx = GRID_X0 + (int'(cur_sel) / ROWS) * COL_PITCH;
        by = GRID_Y0 + (int'(cur_sel) % ROWS) * ROW_PITCH;

        onBorder = (px < BOX_T) || (px >= H_RES - BOX_T) ||
                   (py < BOX_T) || (py >= V_RES - BOX_T);

        inBox = (px >= bx) && (px < bx + BOX_W) &&
                (py >= by) && (py < by + BOX_H);

        nearEdge = (px < bx + BOX_T) || (px >= bx + BOX_W - BOX_T) ||
                   (py < by + BOX_T) || (py >= by + BOX_H - BOX_T);

        boxShown = !blink_en || (phase == PH_VISIBLE);
        white0   = onBorder || (inBox && nearEdge && boxShown);

        inLogo = (px >= LOGO_X) && (px < LOGO_X + LOGO_W) &&
                 (py >= LOGO_Y) && (py < LOGO_Y + LOGO_H);

        if (inLogo) begin
            addr0 = 19'(LOGO_BASE + (px - LOGO_X) +
                        (py - LOGO_Y) * H_RES);
        end else begin
            addr0 = 19'(BLANK_ADDR);
        end
    end

    // Three-stage pipe: address, wait for ROM, final colour.
    // The white flag travels beside valid so it lines up with colorIn.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            v1         <= 1'b0;
            w1         <= 1'b0;
            v2         <= 1'b0;
            w2         <= 1'b0;
            addrToRead <= '0;
            out_valid  <= 1'b0;
            colorOut   <= '0;
            indexOut   <= '0;
        end else begin
            v1 <= pix_valid;
            w1 <= pix_valid & white0;
            if (pix_valid) begin
                addrToRead <= addr0;
            end
            v2        <= v1;
            w2        <= w1;
            out_valid <= v2;
            if (v2) begin
                colorOut <= w2 ? WHITE : colorIn;
                indexOut <= indexIn;
            end
        end
    end

endmodule

// File: tb/tb_vga_menu_overlay_engine.sv
// tb_vga_menu_overlay_engine: randomized scoreboard bench for the overlay engine.
// A scaled screen geometry lets whole frames and the raster wrap run quickly.
module tb_vga_menu_overlay_engine;

    localparam int H  = 80;
    localparam int V  = 48;
    localparam int GX = 10;
    localparam int GY = 20;
    localparam int CP = 30;
    localparam int RP = 8;
    localparam int BW = 20;
    localparam int BH = 7;
    localparam int BT = 2;
    localparam int LB = 25940;
    localparam int LX = 30;
    localparam int LY = 3;
    localparam int LW = 40;
    localparam int LH = 12;
    localparam int BA = 1923;
    localparam int BF = 2;
    localparam int NO = 5;
    localparam int RW = 3;

    logic        clk;
    logic        rstN;
    logic        frame_start;
    logic        pix_valid;
    logic [2:0]  menu_sel;
    logic        blink_en;
    logic [7:0]  indexIn;
    logic [23:0] colorIn;
    logic [18:0] addrToRead;
    logic [7:0]  indexOut;
    logic [23:0] colorOut;
    logic        out_valid;
    logic [2:0]  cur_sel;

    vga_menu_overlay_engine #(
        .SEL_W(3), .NUM_OPTS(NO), .ROWS(RW),
        .H_RES(H), .V_RES(V),
        .GRID_X0(GX), .GRID_Y0(GY),
        .COL_PITCH(CP), .ROW_PITCH(RP),
        .BOX_W(BW), .BOX_H(BH), .BOX_T(BT),
        .LOGO_BASE(LB), .LOGO_X(LX), .LOGO_Y(LY),
        .LOGO_W(LW), .LOGO_H(LH),
        .BLANK_ADDR(BA), .BLINK_FR(BF)
    ) dut (
        .iVGA_CLK(clk),
        .iRST_n(rstN),
        .frame_start(frame_start),
        .pix_valid(pix_valid),
        .menu_sel(menu_sel),
        .blink_en(blink_en),
        .indexIn(indexIn),
        .colorIn(colorIn),
        .addrToRead(addrToRead),
        .indexOut(indexOut),
        .colorOut(colorOut),
        .out_valid(out_valid),
        .cur_sel(cur_sel)
    );

    typedef struct {
        logic [23:0] col;
        logic [7:0]  idx;
        int          cyc;
        int          x;
        int          y;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference state: raster position, drawn selection, frames since
    // the blink last restarted, last address sent to the ROM.
    int          mx, my, msel, mfr;
    logic [18:0] mlast;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    function automatic logic [7:0] romIdx(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]};
    endfunction

    function automatic logic [23:0] romCol(input logic [7:0] i);
        return {i, ~i, i ^ 8'hC3};
    endfunction

    // ROM with one cycle of read latency, palette in the same cycle
    initial begin
        logic [18:0] prevA;
        prevA   = '0;
        indexIn = '0;
        colorIn = '0;
        forever begin
            @(negedge clk);
            indexIn = romIdx(prevA);
            colorIn = romCol(romIdx(prevA));
            prevA   = addrToRead;
        end
    end

    function automatic logic [18:0] expAddr(input int x, input int y);
        if (x >= LX && x < LX + LW && y >= LY && y < LY + LH)
            return 19'(LB + (x - LX) + (y - LY) * H);
        return 19'(BA);
    endfunction

    function automatic bit isWhite(input int x, input int y,
                                   input int sel, input bit shown);
        int  bx, by;
        bit  border, outer, inner;
        border = x < BT || x >= H - BT || y < BT || y >= V - BT;
        bx     = GX + (sel / RW) * CP;
        by     = GY + (sel % RW) * RP;
        outer  = x >= bx && x < bx + BW && y >= by && y < by + BH;
        inner  = x >= bx + BT && x < bx + BW - BT &&
                 y >= by + BT && y < by + BH - BT;
        return border || (outer && !inner && shown);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks = checks + 1;
        if (act !== want) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h want=%0h cyc=%0d",
                     nm, act, want, cyc);
        end
    endtask

    // One clock of stimulus; the reference model advances alongside
    task automatic step(input bit fs, input bit pv, input int sel,
                        input bit ben);
        logic [18:0] a;
        bit          shown;
        int          px, py, nsel;
        frame_start = fs;
        pix_valid   = pv;
        menu_sel    = 3'(sel);
        blink_en    = ben;
        px = mx;
        py = my;
        if (!rstN) begin
            mx = 0; my = 0; msel = 0; mfr = 0; mlast = '0;
            sb.delete();
        end else begin
            if (pv) begin
                a     = expAddr(mx, my);
                shown = !ben || ((mfr / BF) % 2 == 0);
                sb.push_back('{isWhite(mx, my, msel, shown) ?
                               24'hFFFFFF : romCol(romIdx(a)),
                               romIdx(a), cyc, mx, my});
                mlast = a;
                if (mx == H - 1) begin
                    mx = 0;
                    my = (my == V - 1) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end
            if (fs) begin
                mx   = 0;
                my   = 0;
                nsel = (sel > NO - 1) ? NO - 1 : sel;
                if (nsel != msel) begin
                    msel = nsel;
                    mfr  = 0;
                end else begin
                    mfr = mfr + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("addrToRead", 32'(addrToRead), 32'(mlast));
        if (!rstN) begin
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_colorOut", 32'(colorOut), 0);
            chk("rst_indexOut", 32'(indexOut), 0);
            chk("rst_cur_sel", 32'(cur_sel), 0);
        end else begin
            if (fs) chk("cur_sel", 32'(cur_sel), 32'(msel));
            if (fs && sel == 7) chk("clamp_sel7", 32'(cur_sel), 4);
            if (pv && px == LX && py == LY)
                chk("logo_first", 32'(addrToRead), 25940);
            if (pv && px == LX + LW - 1 && py == LY + LH - 1)
                chk("logo_last", 32'(addrToRead), 26859);
            if (pv && px == LX - 1 && py == LY)
                chk("logo_left", 32'(addrToRead), 1923);
        end
    endtask

    task automatic runPix(input int n, input int sel, input bit ben,
                          input int gapPct);
        int done;
        done = 0;
        while (done < n) begin
            if ($urandom_range(99) < gapPct) begin
                step(1'b0, 1'b0, sel, ben);
            end else begin
                step(1'b0, 1'b1, sel, ben);
                done = done + 1;
            end
        end
    endtask

    // Monitor: every presented output pops one expected pixel
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstN === 1'b1) begin
                if (out_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks   = checks + 1;
                        failures = failures + 1;
                        $display("FAIL spurious_out_valid cyc=%0d", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("colorOut(%0d,%0d)", e.x, e.y),
                            32'(colorOut), 32'(e.col));
                        chk("indexOut", 32'(indexOut), 32'(e.idx));
                        chk("latency", 32'(cyc - e.cyc), 3);
                    end
                end else if (sb.size() > 0 && cyc - sb[0].cyc > 3) begin
                    checks   = checks + 1;
                    failures = failures + 1;
                    $display("FAIL missing_out pixel=(%0d,%0d) got=none want=valid cyc=%0d",
                             sb[0].x, sb[0].y, cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rstN        = 1'b0;
        frame_start = 1'b0;
        pix_valid   = 1'b1;
        menu_sel    = 3'd5;
        blink_en    = 1'b1;
        mx = 0; my = 0; msel = 0; mfr = 0; mlast = '0;

        repeat (4) step(1'b0, 1'b1, int'($urandom_range(7)), 1'b1);
        rstN = 1'b1;

        // Unlatched request: box stays at option 0
        runPix(50, 5, 1'b1, 20);

        // Select option 3, then request 6 mid-frame (must not tear)
        step(1'b1, 1'b0, 3, 1'b1);
        runPix(1800, 3, 1'b1, 20);
        runPix(H * V - 1800, 6, 1'b1, 20);

        // Cross the (79,47)->(0,0) wrap with gaps, no frame_start
        runPix(200, 6, 1'b1, 30);

        // Clamp: 7 draws option 4; then steady blink frames
        step(1'b1, 1'b0, 7, 1'b1);
        runPix(2880, 7, 1'b1, 20);
        for (int f = 0; f < 6; f++) begin
            step(1'b1, 1'b0, 7, 1'b1);
            runPix(2880, 7, 1'b1, 20);
        end

        // Change selection while hidden: visible on the next frame
        step(1'b1, 1'b0, 2, 1'b1);
        runPix(H * V, 2, 1'b1, 20);

        // Blink disabled: steady even in a hidden phase
        step(1'b1, 1'b0, 2, 1'b0);
        runPix(2400, 2, 1'b0, 20);
        step(1'b1, 1'b0, 2, 1'b0);
        runPix(H * V, 2, 1'b0, 20);

        // Mid-frame reset with pixels in flight
        step(1'b1, 1'b0, 1, 1'b1);
        runPix(500, 1, 1'b1, 20);
        rstN = 1'b0;
        repeat (4) step(1'b0, 1'b1, int'($urandom_range(7)), 1'b1);
        rstN = 1'b1;
        runPix(300, 1, 1'b1, 20);

        repeat (6) step(1'b0, 1'b0, 1, 1'b1);
        chk("drain_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
